// File: rtl/mem_wr.sv
// Frame-capture writer: streams one SOF-aligned frame into the frame BRAM, then raises a stretched request for the read side.
// Optional feature: define MEM_WR_SOF_ERR_EN to enable the sticky early-SOF error flag (o_sof_err); otherwise it is tied to 0.
module mem_wr #(
  parameter int BRAM_DEPTH = 16384,
  parameter int DW         = 12,
  parameter int REQ_LEN    = 4,
  localparam int AW        = $clog2(BRAM_DEPTH)
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_en,
  input  logic          i_valid,
  input  logic [DW-1:0] i_data,
  input  logic          i_sof,
  output logic          o_wr,
  output logic [AW-1:0] o_waddr,
  output logic [DW-1:0] o_wdata,
  output logic          o_req,
  output logic          o_busy,
  output logic          o_done,
  output logic          o_sof_err
);

  localparam int RW = (REQ_LEN > 1) ? $clog2(REQ_LEN) : 1;
  localparam logic [AW-1:0] LAST_ADDR = AW'(BRAM_DEPTH - 1);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT_SOF = 2'd1,
    CAPTURE  = 2'd2,
    REQ      = 2'd3
  } state_t;

  state_t          state, state_nx;
  logic [AW-1:0]   addr, addr_nx;
  logic [RW-1:0]   cnt, cnt_nx;
  logic            wr_nx, req_nx, done_nx;
  logic [AW-1:0]   waddr_nx;
  logic [DW-1:0]   wdata_nx;

`ifdef MEM_WR_SOF_ERR_EN
  logic sof_err_q, sof_err_nx;
`endif

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state   <= IDLE;
      addr    <= '0;
      cnt     <= '0;
      o_wr    <= 1'b0;
      o_waddr <= '0;
      o_wdata <= '0;
      o_req   <= 1'b0;
      o_done  <= 1'b0;
    end else begin
      state   <= state_nx;
      addr    <= addr_nx;
      cnt     <= cnt_nx;
      o_wr    <= wr_nx;
      o_waddr <= waddr_nx;
      o_wdata <= wdata_nx;
      o_req   <= req_nx;
      o_done  <= done_nx;
    end
  end

`ifdef MEM_WR_SOF_ERR_EN
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) sof_err_q <= 1'b0;
    else       sof_err_q <= sof_err_nx;
  end
  assign o_sof_err = sof_err_q;
`else
  assign o_sof_err = 1'b0;
`endif

  always_comb begin
    state_nx = state;
    addr_nx  = addr;
    cnt_nx   = cnt;
    wr_nx    = 1'b0;
    waddr_nx = o_waddr;
    wdata_nx = o_wdata;
    req_nx   = o_req;
    done_nx  = 1'b0;
`ifdef MEM_WR_SOF_ERR_EN
    sof_err_nx = sof_err_q;
`endif
    case (state)
      IDLE: begin
        req_nx = 1'b0;
        if (i_en) begin
          state_nx = WAIT_SOF;
`ifdef MEM_WR_SOF_ERR_EN
          sof_err_nx = 1'b0;
`endif
        end
      end
      WAIT_SOF: begin
        if (i_valid && i_sof) begin
          wr_nx    = 1'b1;
          waddr_nx = '0;
          wdata_nx = i_data;
          addr_nx  = AW'(1);
          state_nx = CAPTURE;
        end
      end
      CAPTURE: begin
        if (i_valid) begin
          wr_nx    = 1'b1;
          wdata_nx = i_data;
          if (i_sof) begin
            // Early SOF restarts the frame; it takes priority over completion.
            waddr_nx = '0;
            addr_nx  = AW'(1);
`ifdef MEM_WR_SOF_ERR_EN
            sof_err_nx = 1'b1;
`endif
          end else begin
            waddr_nx = addr;
            if (addr == LAST_ADDR) begin
              addr_nx  = '0;
              state_nx = REQ;
              req_nx   = 1'b1;
              done_nx  = 1'b1;
              cnt_nx   = RW'(REQ_LEN - 1);
            end else begin
              addr_nx = addr + AW'(1);
            end
          end
        end
      end
      REQ: begin
        // cnt counts the remaining request cycles after the current one.
        if (cnt == '0) begin
          req_nx   = 1'b0;
          state_nx = IDLE;
        end else begin
          cnt_nx = cnt - RW'(1);
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  assign o_busy = (state == WAIT_SOF) || (state == CAPTURE);

endmodule

// File: tb/tb_mem_wr.sv
// Bench for mem_wr with a small frame (16 words) and a 4-cycle request.
module tb_mem_wr;
  localparam int BRAM_DEPTH = 16;
  localparam int DW         = 12;
  localparam int REQ_LEN    = 4;
  localparam int AW         = $clog2(BRAM_DEPTH);
  localparam int W          = 32 + AW + DW;
`ifdef MEM_WR_SOF_ERR_EN
  localparam logic SOF_EXP = 1'b1;
`else
  localparam logic SOF_EXP = 1'b0;
`endif

  logic          clk, rst, i_en, i_valid, i_sof;
  logic [DW-1:0] i_data;
  logic          o_wr, o_req, o_busy, o_done, o_sof_err;
  logic [AW-1:0] o_waddr;
  logic [DW-1:0] o_wdata;

  mem_wr #(.BRAM_DEPTH(BRAM_DEPTH), .DW(DW), .REQ_LEN(REQ_LEN)) dut (
    .i_clk(clk), .i_rst(rst), .i_en(i_en), .i_valid(i_valid), .i_data(i_data),
    .i_sof(i_sof), .o_wr(o_wr), .o_waddr(o_waddr), .o_wdata(o_wdata),
    .o_req(o_req), .o_busy(o_busy), .o_done(o_done), .o_sof_err(o_sof_err)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [31:0] cyc;
  always @(posedge clk) cyc <= cyc + 32'd1;

  // scoreboard state
  logic [W-1:0] exp_q[$];
  int checks, errors, req_cycles, done_cnt;
  logic prev_req;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, want);
    end
  endtask

  // monitor: pops one expected write per observed o_wr
  always @(negedge clk) begin
    if (rst) begin
      prev_req = 1'b0;
    end else begin
      if (o_wr) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_write: cyc=%0d addr=%0d data=%h, expected none", cyc, o_waddr, o_wdata);
        end else begin
          logic [W-1:0] e;
          e = exp_q.pop_front();
          if ({cyc, o_waddr, o_wdata} !== e) begin
            errors++;
            $display("FAIL write: got cyc=%0d addr=%0d data=%h expected cyc=%0d addr=%0d data=%h",
                     cyc, o_waddr, o_wdata, e[W-1 -: 32], e[AW+DW-1 -: AW], e[DW-1:0]);
          end
        end
      end
      if (o_req) begin
        req_cycles++;
        checks++;
        if (o_busy !== 1'b0) begin
          errors++;
          $display("FAIL busy_in_req: got %b expected 0", o_busy);
        end
      end
      if (o_done) begin
        done_cnt++;
        checks++;
        if (!(o_req && !prev_req)) begin
          errors++;
          $display("FAIL done_align: req=%b prev_req=%b expected 1/0", o_req, prev_req);
        end
      end
      prev_req = o_req;
    end
  end

  // driver tasks
  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
      i_valid = 1'b0; i_sof = 1'b0;
    end
  endtask

  task automatic beat(input logic s, input logic [DW-1:0] d, input logic [AW-1:0] a);
    @(posedge clk); #1;
    i_valid = 1'b1; i_sof = s; i_data = d;
    exp_q.push_back({cyc + 32'd1, a, d});
  endtask

  task automatic junk(input logic [DW-1:0] d);
    @(posedge clk); #1;
    i_valid = 1'b1; i_sof = 1'b0; i_data = d;
  endtask

  task automatic end_frame(input string tag);
    idle(REQ_LEN + 4);
    chk({tag, "_req_len"}, req_cycles, REQ_LEN);
    chk({tag, "_done_cnt"}, done_cnt, 1);
    chk({tag, "_pending"}, exp_q.size(), 0);
    req_cycles = 0;
    done_cnt = 0;
  endtask

  initial begin
    checks = 0; errors = 0; req_cycles = 0; done_cnt = 0; prev_req = 1'b0;
    cyc = '0;
    rst = 1'b1; i_en = 1'b0; i_valid = 1'b0; i_sof = 1'b0; i_data = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_wr", o_wr, 0);
    chk("rst_req", o_req, 0);
    chk("rst_busy", o_busy, 0);
    chk("rst_done", o_done, 0);
    chk("rst_sof_err", o_sof_err, 0);
    chk("rst_waddr", o_waddr, 0);
    chk("rst_wdata", o_wdata, 0);
    rst = 1'b0;
    i_en = 1'b1;
    idle(3);
    chk("wait_sof_busy", o_busy, 1);

    // full contiguous frame
    for (int i = 0; i < 16; i++) begin
      beat(i == 0, 12'(i), 4'(i));
      if (i == 5) chk("capture_busy", o_busy, 1);
    end
    end_frame("full");

    // gapped stream
    for (int i = 0; i < 16; i++) begin
      beat(i == 0, 12'h200 + 12'(i), 4'(i));
      idle(1);
    end
    end_frame("gapped");

    // junk before SOF
    for (int i = 0; i < 5; i++) junk(12'h300 + 12'(i));
    beat(1'b1, 12'hABC, 4'd0);
    for (int i = 1; i < 16; i++) beat(1'b0, 12'h400 + 12'(i), 4'(i));
    end_frame("pre_sof");

    // early SOF resync
    beat(1'b1, 12'h050, 4'd0);
    for (int i = 1; i < 8; i++) beat(1'b0, 12'h100 + 12'(i), 4'(i));
    beat(1'b1, 12'h5A5, 4'd0);
    for (int i = 1; i < 16; i++) begin
      beat(1'b0, 12'h500 + 12'(i), 4'(i));
      if (i == 1) chk("sof_err_set", o_sof_err, SOF_EXP);
    end
    end_frame("early_sof");
    chk("sof_err_clear", o_sof_err, 0);

    // beats during the request are dropped
    for (int i = 0; i < 16; i++) beat(i == 0, 12'h600 + 12'(i), 4'(i));
    for (int i = 0; i < 3; i++) junk(12'h7F0 + 12'(i));
    end_frame("req_beats");

    // next SOF lands at address 0, then reset mid-capture after address 9
    beat(1'b1, 12'h777, 4'd0);
    for (int i = 1; i < 10; i++) beat(1'b0, 12'h700 + 12'(i), 4'(i));
    idle(1);
    @(negedge clk); #1;
    rst = 1'b1;
    #1;
    chk("mid_rst_wr", o_wr, 0);
    chk("mid_rst_busy", o_busy, 0);
    chk("mid_rst_waddr", o_waddr, 0);
    chk("mid_rst_wdata", o_wdata, 0);
    chk("mid_rst_pending", exp_q.size(), 0);
    @(posedge clk); #1;
    rst = 1'b0;
    req_cycles = 0;
    done_cnt = 0;
    idle(3);
    chk("post_rst_no_req", req_cycles, 0);
    for (int i = 0; i < 16; i++) beat(i == 0, 12'h800 + 12'(i), 4'(i));
    end_frame("post_rst");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
